pipelined_addsub: RTL and testbench

PIPELINED_ADDSUB -- requirements
Module: pipelined_addsub

---
 rtl/pipelined_addsub.sv | 118 +++++++++++
 tb/tb_pipelined_addsub.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_addsub.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_addsub
// Brief    : STAGES-deep carry-pipelined add/subtract with valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4     // must be >= 2 and divide WIDTH evenly
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic [1:0]       op,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] answer,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int SW = WIDTH / STAGES;

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] carry_q;
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  a_q   [STAGES-1];
    logic [WIDTH-1:0]  b_q   [STAGES-1];
    logic              overflow_q;
    logic              zero_q;
    logic              negative_q;

    logic              advance;
    logic [STAGES-1:0] stg_v;
    logic [STAGES-1:0] stg_c;
    logic [STAGES-1:0] carry_d;
    logic [WIDTH-1:0]  stg_a [STAGES];
    logic [WIDTH-1:0]  stg_b [STAGES];
    logic [WIDTH-1:0]  stg_s [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];
    logic [SW:0]       part  [STAGES];
    logic              overflow_d;

    assign advance = !valid_q[STAGES-1] || out_ready;

    // Operands shift right one slice per stage, so every stage adds bits [SW-1:0];
    // sum slices enter at the top and drift down into place.
    always_comb begin
        stg_v[0] = in_valid;
        stg_a[0] = input1;
        stg_b[0] = op[0] ? ~input2 : input2;
        stg_c[0] = op[1] ? cin : op[0];
        stg_s[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            stg_v[k] = valid_q[k-1];
            stg_a[k] = a_q[k-1];
            stg_b[k] = b_q[k-1];
            stg_c[k] = carry_q[k-1];
            stg_s[k] = sum_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            part[k]    = {1'b0, stg_a[k][SW-1:0]} + {1'b0, stg_b[k][SW-1:0]}
                       + {{SW{1'b0}}, stg_c[k]};
            carry_d[k] = part[k][SW];
            sum_d[k]   = {part[k][SW-1:0], {(WIDTH-SW){1'b0}}} | (stg_s[k] >> SW);
        end
        overflow_d = (stg_a[STAGES-1][SW-1] == stg_b[STAGES-1][SW-1])
                  && (part[STAGES-1][SW-1] != stg_a[STAGES-1][SW-1]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q    <= '0;
            carry_q    <= '0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
            negative_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                sum_q[k] <= '0;
            end
        end else if (advance) begin
            valid_q    <= stg_v;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            zero_q     <= (sum_d[STAGES-1] == '0);
            negative_q <= sum_d[STAGES-1][WIDTH-1];
            for (int k = 0; k < STAGES; k++) begin
                sum_q[k] <= sum_d[k];
            end
        end
    end

    // Operand slices carry no control meaning, so they need no reset.
    always_ff @(posedge clk) begin
        if (advance) begin
            for (int k = 0; k < STAGES-1; k++) begin
                a_q[k] <= stg_a[k] >> SW;
                b_q[k] <= stg_b[k] >> SW;
            end
        end
    end

    assign in_ready  = advance;
    assign out_valid = valid_q[STAGES-1];
    assign answer    = sum_q[STAGES-1];
    assign carry_out = carry_q[STAGES-1];
    assign overflow  = overflow_q;
    assign zero      = zero_q;
    assign negative  = negative_q;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_addsub.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_addsub
// Brief    : Directed and randomised self-checking bench for pipelined_addsub.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_addsub;

    localparam int WIDTH  = 16;
    localparam int STAGES = 4;
    localparam int N_RAND = 2000;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] input1;
    logic [WIDTH-1:0] input2;
    logic [1:0]       op;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] answer;
    logic             carry_out;
    logic             overflow;
    logic             zero;
    logic             negative;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipelined_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .input1   (input1),
        .input2   (input2),
        .op       (op),
        .cin      (cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .answer   (answer),
        .carry_out(carry_out),
        .overflow (overflow),
        .zero     (zero),
        .negative (negative)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packed as {carry_out, overflow, zero, negative, answer}
    function automatic logic [19:0] dut_out();
        return {carry_out, overflow, zero, negative, answer};
    endfunction

    function automatic logic [19:0] model(input logic [1:0] o, input logic [15:0] a,
                                          input logic [15:0] b, input logic c);
        logic [15:0] bp;
        logic        c0;
        logic [16:0] s;
        bp = o[0] ? ~b : b;
        c0 = o[1] ? c : o[0];
        s  = {1'b0, a} + {1'b0, bp} + {16'd0, c0};
        return {s[16], (a[15] == bp[15]) && (s[15] != a[15]), s[15:0] == 16'd0, s[15], s[15:0]};
    endfunction

    task automatic run_one(input string tag, input logic [1:0] o, input logic [15:0] a,
                           input logic [15:0] b, input logic c, input logic [19:0] exp);
        int lat;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op        = o;
        input1    = a;
        input2    = b;
        cin       = c;
        #1;
        check({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, lat, 4);
        check({tag, " result"}, {12'd0, dut_out()}, {12'd0, exp});
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] held;
        logic [19:0] expq[$];
        logic [19:0] e;
        int idx, oidx, extra, acc, got, cyc;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        input1 = '0; input2 = '0; op = 2'b00; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset outputs", {12'd0, dut_out()}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("in_ready after reset", {31'd0, in_ready}, 32'd1);

        run_one("add 5432+1234", 2'b00, 16'd5432, 16'd1234, 1'b0, 20'h01A0A);
        run_one("add ffff+1",    2'b00, 16'hFFFF, 16'h0001, 1'b0, 20'hA0000);
        run_one("adc 7fff+0+1",  2'b10, 16'h7FFF, 16'h0000, 1'b1, 20'h58000);
        run_one("sub 5-7",       2'b01, 16'd5,    16'd7,    1'b0, 20'h1FFFE);
        run_one("sbc 7-5-1",     2'b11, 16'd7,    16'd5,    1'b0, 20'h80001);

        // Back-to-back stream with a three-cycle consumer stall
        idx = 0; oidx = 0; held = '0;
        for (int c = 0; c < 40 && oidx < 6; c++) begin
            in_valid  = (idx < 6);
            input1    = 16'(idx + 1);
            input2    = 16'(idx + 1);
            op        = 2'b00;
            cin       = 1'b0;
            out_ready = !(c >= 5 && c <= 7);
            #1;
            if (c == 5) held = answer;
            if (c >= 5 && c <= 7) check("stall in_ready", {31'd0, in_ready}, 32'd0);
            if (c == 6 || c == 7) check("stall answer held", {16'd0, answer}, {16'd0, held});
            if (out_valid && out_ready) begin
                check("stream answer", {16'd0, answer}, 32'(2 * (oidx + 1)));
                oidx++;
            end
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("stream count", oidx, 6);
        extra = 0;
        repeat (6) begin
            #1;
            if (out_valid) extra++;
            @(posedge clk); #1;
        end
        check("stream no duplicates", extra, 0);

        // Reset with three operations in flight
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            input1   = 16'(100 + i);
            input2   = 16'd1;
            op       = 2'b00;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk); #1;
        check("midreset out_valid", {31'd0, out_valid}, 32'd0);
        check("midreset outputs", {12'd0, dut_out()}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("midreset in_ready", {31'd0, in_ready}, 32'd1);
        extra = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) extra++;
        end
        check("midreset no stale", extra, 0);

        // Random traffic against the reference model
        acc = 0; got = 0; cyc = 0;
        while (got < N_RAND && cyc < 40000) begin
            in_valid  = (acc < N_RAND) && ($urandom_range(0, 9) < 7);
            input1    = 16'($urandom);
            input2    = 16'($urandom);
            op        = 2'($urandom_range(0, 3));
            cin       = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            if (out_valid && out_ready) begin
                check("rand expected pending", {31'd0, expq.size() != 0}, 32'd1);
                if (expq.size() != 0) begin
                    e = expq.pop_front();
                    check("rand result", {12'd0, dut_out()}, {12'd0, e});
                end
                got++;
            end
            if (in_valid && in_ready) begin
                expq.push_back(model(op, input1, input2, cin));
                acc++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        check("rand output count", got, N_RAND);
        check("rand queue drained", expq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
